// File: rtl/jtag_tap_core.sv
`default_nettype none
// ============================================================================
// Module   : jtag_tap_core
// Brief    : IEEE 1149.1 TAP controller with IR, BYPASS, IDCODE and BSR hooks.
// Revision : 1.0 - initial release
// ============================================================================
module jtag_tap_core #(
  parameter int                    IR_WIDTH     = 4,
  parameter logic [31:0]           IDCODE_VALUE = 32'h1000_0001,
  parameter logic [IR_WIDTH-1:0]   OP_EXTEST    = '0,
  parameter logic [IR_WIDTH-1:0]   OP_SAMPLE    = {{(IR_WIDTH-1){1'b0}}, 1'b1},
  parameter logic [IR_WIDTH-1:0]   OP_IDCODE    = {{(IR_WIDTH-2){1'b0}}, 2'b10},
  parameter logic [IR_WIDTH-1:0]   OP_BYPASS    = '1
) (
  input  logic                TCK,
  input  logic                TRST,
  input  logic                TMS,
  input  logic                TDI,
  input  logic                BSR_SO,
  output logic                TDO,
  output logic                TDO_EN,
  output logic [3:0]          STATE,
  output logic [IR_WIDTH-1:0] IR,
  output logic                BSR_CAPTURE,
  output logic                BSR_SHIFT,
  output logic                BSR_UPDATE,
  output logic                EXTEST
);

  localparam logic [3:0] c_TLR    = 4'd0;
  localparam logic [3:0] c_RTI    = 4'd1;
  localparam logic [3:0] c_SEL_DR = 4'd2;
  localparam logic [3:0] c_CAP_DR = 4'd3;
  localparam logic [3:0] c_SH_DR  = 4'd4;
  localparam logic [3:0] c_EX1_DR = 4'd5;
  localparam logic [3:0] c_PA_DR  = 4'd6;
  localparam logic [3:0] c_EX2_DR = 4'd7;
  localparam logic [3:0] c_UPD_DR = 4'd8;
  localparam logic [3:0] c_SEL_IR = 4'd9;
  localparam logic [3:0] c_CAP_IR = 4'd10;
  localparam logic [3:0] c_SH_IR  = 4'd11;
  localparam logic [3:0] c_EX1_IR = 4'd12;
  localparam logic [3:0] c_PA_IR  = 4'd13;
  localparam logic [3:0] c_EX2_IR = 4'd14;
  localparam logic [3:0] c_UPD_IR = 4'd15;

  localparam logic [IR_WIDTH-1:0] c_IR_CAPTURE = {{(IR_WIDTH-1){1'b0}}, 1'b1};

  logic [3:0]          r_state;
  logic [3:0]          w_state_next;
  logic [IR_WIDTH-1:0] r_ir;
  logic [IR_WIDTH-1:0] r_ir_sr;
  logic                r_bypass;
  logic [31:0]         r_idcode_sr;
  logic                w_sel_extest;
  logic                w_sel_sample;
  logic                w_sel_idcode;
  logic                w_sel_bypass;
  logic                w_sel_bsr;
  logic                w_tdo_next;

  always_comb begin
    w_state_next = c_TLR;
    case (r_state)
      c_TLR:    w_state_next = TMS ? c_TLR    : c_RTI;
      c_RTI:    w_state_next = TMS ? c_SEL_DR : c_RTI;
      c_SEL_DR: w_state_next = TMS ? c_SEL_IR : c_CAP_DR;
      c_CAP_DR: w_state_next = TMS ? c_EX1_DR : c_SH_DR;
      c_SH_DR:  w_state_next = TMS ? c_EX1_DR : c_SH_DR;
      c_EX1_DR: w_state_next = TMS ? c_UPD_DR : c_PA_DR;
      c_PA_DR:  w_state_next = TMS ? c_EX2_DR : c_PA_DR;
      c_EX2_DR: w_state_next = TMS ? c_UPD_DR : c_SH_DR;
      c_UPD_DR: w_state_next = TMS ? c_SEL_DR : c_RTI;
      c_SEL_IR: w_state_next = TMS ? c_TLR    : c_CAP_IR;
      c_CAP_IR: w_state_next = TMS ? c_EX1_IR : c_SH_IR;
      c_SH_IR:  w_state_next = TMS ? c_EX1_IR : c_SH_IR;
      c_EX1_IR: w_state_next = TMS ? c_UPD_IR : c_PA_IR;
      c_PA_IR:  w_state_next = TMS ? c_EX2_IR : c_PA_IR;
      c_EX2_IR: w_state_next = TMS ? c_UPD_IR : c_SH_IR;
      c_UPD_IR: w_state_next = TMS ? c_SEL_DR : c_RTI;
      default:  w_state_next = c_TLR;
    endcase
  end

  // Any opcode that is not a recognised instruction falls back to BYPASS.
  assign w_sel_extest = (r_ir == OP_EXTEST);
  assign w_sel_sample = (r_ir == OP_SAMPLE);
  assign w_sel_idcode = (r_ir == OP_IDCODE);
  assign w_sel_bsr    = w_sel_extest | w_sel_sample;
  assign w_sel_bypass = (r_ir == OP_BYPASS) | ~(w_sel_bsr | w_sel_idcode);

  always_ff @(posedge TCK or posedge TRST) begin
    if (TRST) begin
      r_state     <= c_TLR;
      r_ir_sr     <= '0;
      r_bypass    <= 1'b0;
      r_idcode_sr <= '0;
    end else begin
      r_state <= w_state_next;
      if (r_state == c_CAP_IR)
        r_ir_sr <= c_IR_CAPTURE;
      else if (r_state == c_SH_IR)
        r_ir_sr <= {TDI, r_ir_sr[IR_WIDTH-1:1]};
      if (w_sel_bypass && r_state == c_CAP_DR)
        r_bypass <= 1'b0;
      else if (w_sel_bypass && r_state == c_SH_DR)
        r_bypass <= TDI;
      if (w_sel_idcode && r_state == c_CAP_DR)
        r_idcode_sr <= IDCODE_VALUE | 32'd1;
      else if (w_sel_idcode && r_state == c_SH_DR)
        r_idcode_sr <= {TDI, r_idcode_sr[31:1]};
    end
  end

  always_comb begin
    w_tdo_next = 1'b0;
    if (r_state == c_SH_IR)
      w_tdo_next = r_ir_sr[0];
    else if (r_state == c_SH_DR) begin
      if (w_sel_bsr)
        w_tdo_next = BSR_SO;
      else if (w_sel_idcode)
        w_tdo_next = r_idcode_sr[0];
      else
        w_tdo_next = r_bypass;
    end
  end

  // Falling-edge domain: TDO launch and instruction update.
  always_ff @(negedge TCK or posedge TRST) begin
    if (TRST) begin
      r_ir   <= OP_IDCODE;
      TDO    <= 1'b0;
      TDO_EN <= 1'b0;
    end else begin
      TDO    <= w_tdo_next;
      TDO_EN <= (r_state == c_SH_IR) || (r_state == c_SH_DR);
      if (r_state == c_TLR)
        r_ir <= OP_IDCODE;
      else if (r_state == c_UPD_IR)
        r_ir <= r_ir_sr;
    end
  end

  assign STATE       = r_state;
  assign IR          = r_ir;
  assign EXTEST      = w_sel_extest;
  assign BSR_CAPTURE = w_sel_bsr && (r_state == c_CAP_DR);
  assign BSR_SHIFT   = w_sel_bsr && (r_state == c_SH_DR);
  assign BSR_UPDATE  = w_sel_bsr && (r_state == c_UPD_DR);

endmodule
`default_nettype wire

// File: tb/tb_jtag_tap_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_jtag_tap_core
// Brief    : Directed self-checking bench for jtag_tap_core.
// Revision : 1.0 - initial release
// ============================================================================
module tb_jtag_tap_core;

  logic       TCK = 1'b0;
  logic       TRST = 1'b0;
  logic       TMS = 1'b1;
  logic       TDI = 1'b0;
  logic       BSR_SO = 1'b0;
  logic       TDO;
  logic       TDO_EN;
  logic [3:0] STATE;
  logic [3:0] IR;
  logic       BSR_CAPTURE;
  logic       BSR_SHIFT;
  logic       BSR_UPDATE;
  logic       EXTEST;

  int checks = 0;
  int errors = 0;

  jtag_tap_core dut (
    .TCK(TCK), .TRST(TRST), .TMS(TMS), .TDI(TDI), .BSR_SO(BSR_SO),
    .TDO(TDO), .TDO_EN(TDO_EN), .STATE(STATE), .IR(IR),
    .BSR_CAPTURE(BSR_CAPTURE), .BSR_SHIFT(BSR_SHIFT), .BSR_UPDATE(BSR_UPDATE),
    .EXTEST(EXTEST)
  );

  always #5 TCK = ~TCK;

  // Apply TMS/TDI for the next rising edge, then return 1 ns after the
  // following falling edge so state, IR and TDO have all settled.
  task automatic drive(input logic tms, input logic tdi);
    TMS = tms;
    TDI = tdi;
    @(negedge TCK);
    #1;
  endtask

  task automatic load_ir(input logic [3:0] op);
    drive(1'b1, 1'b0);
    drive(1'b1, 1'b0);
    drive(1'b0, 1'b0);
    drive(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) drive(i == 3, op[i]);
    drive(1'b1, 1'b0);
    drive(1'b0, 1'b0);
  endtask

  task automatic test_reset;
    #1 TRST = 1'b1;
    #2;
    checks++; if (STATE !== 4'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", STATE); end
    checks++; if (IR !== 4'h2) begin errors++; $display("FAIL reset_ir: got %0h expected 2", IR); end
    checks++; if (TDO !== 1'b0 || TDO_EN !== 1'b0) begin errors++; $display("FAIL reset_tdo: got tdo=%b en=%b expected 0/0", TDO, TDO_EN); end
    TMS = 1'b0;
    repeat (2) @(negedge TCK);
    #1;
    checks++; if (STATE !== 4'd0) begin errors++; $display("FAIL reset_hold: got %0d expected 0", STATE); end
    TRST = 1'b0;
    drive(1'b0, 1'b0);
    checks++; if (STATE !== 4'd1) begin errors++; $display("FAIL reset_first_tr: got %0d expected 1", STATE); end
  endtask

  task automatic test_idcode_scan;
    logic [31:0] exp_id;
    exp_id = 32'h1000_0001;
    drive(1'b1, 1'b0);
    drive(1'b0, 1'b0);
    checks++; if (STATE !== 4'd3 || TDO_EN !== 1'b0) begin errors++; $display("FAIL id_capdr: got state=%0d en=%b expected 3/0", STATE, TDO_EN); end
    drive(1'b0, 1'b0);
    for (int i = 0; i < 32; i++) begin
      checks++;
      if (TDO !== exp_id[i] || TDO_EN !== 1'b1) begin
        errors++; $display("FAIL id_bit%0d: got tdo=%b en=%b expected %b/1", i, TDO, TDO_EN, exp_id[i]);
      end
      drive(i == 31, 1'b0);
    end
    checks++; if (STATE !== 4'd5 || TDO_EN !== 1'b0) begin errors++; $display("FAIL id_exit: got state=%0d en=%b expected 5/0", STATE, TDO_EN); end
    drive(1'b1, 1'b0);
    drive(1'b0, 1'b0);
  endtask

  task automatic test_ir_scan;
    logic [3:0] exp_tdo;
    exp_tdo = 4'b0001;
    drive(1'b1, 1'b0);
    drive(1'b1, 1'b0);
    drive(1'b0, 1'b0);
    drive(1'b0, 1'b0);
    checks++; if (STATE !== 4'd11) begin errors++; $display("FAIL ir_enter: got %0d expected 11", STATE); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (TDO !== exp_tdo[i] || TDO_EN !== 1'b1) begin
        errors++; $display("FAIL ir_tdo%0d: got tdo=%b en=%b expected %b/1", i, TDO, TDO_EN, exp_tdo[i]);
      end
      drive(i == 3, 1'b1);
    end
    drive(1'b1, 1'b0);
    drive(1'b0, 1'b0);
    checks++; if (IR !== 4'hF || STATE !== 4'd1) begin errors++; $display("FAIL ir_update: got ir=%0h state=%0d expected f/1", IR, STATE); end
  endtask

  task automatic test_bypass;
    logic [3:0] tdi_pat;
    logic [3:0] exp_tdo;
    tdi_pat = 4'b1101;
    exp_tdo = 4'b1010;
    load_ir(4'h5);
    checks++; if (IR !== 4'h5) begin errors++; $display("FAIL byp_ir: got %0h expected 5", IR); end
    drive(1'b1, 1'b0);
    drive(1'b0, 1'b0);
    drive(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (TDO !== exp_tdo[i]) begin errors++; $display("FAIL byp_tdo%0d: got %b expected %b", i, TDO, exp_tdo[i]); end
      drive(i == 3, tdi_pat[i]);
    end
    drive(1'b0, 1'b0);
    checks++; if (STATE !== 4'd6) begin errors++; $display("FAIL byp_pause: got %0d expected 6", STATE); end
    drive(1'b1, 1'b0);
    checks++; if (STATE !== 4'd7) begin errors++; $display("FAIL byp_exit2: got %0d expected 7", STATE); end
    drive(1'b0, 1'b0);
    checks++; if (STATE !== 4'd4 || TDO !== 1'b1) begin errors++; $display("FAIL byp_resume: got state=%0d tdo=%b expected 4/1", STATE, TDO); end
    drive(1'b1, 1'b0);
    drive(1'b1, 1'b0);
    drive(1'b0, 1'b0);
  endtask

  task automatic test_tms_reset;
    drive(1'b1, 1'b0);
    drive(1'b0, 1'b0);
    drive(1'b0, 1'b0);
    checks++; if (STATE !== 4'd4) begin errors++; $display("FAIL tms_shdr: got %0d expected 4", STATE); end
    repeat (5) drive(1'b1, 1'b0);
    checks++; if (STATE !== 4'd0 || IR !== 4'h2) begin errors++; $display("FAIL tms_tlr: got state=%0d ir=%0h expected 0/2", STATE, IR); end
    drive(1'b0, 1'b0);
    checks++; if (STATE !== 4'd1) begin errors++; $display("FAIL tms_rti: got %0d expected 1", STATE); end
  endtask

  task automatic test_extest;
    logic [3:0] so_pat;
    so_pat = 4'b0110;
    load_ir(4'h0);
    checks++; if (EXTEST !== 1'b1) begin errors++; $display("FAIL ext_flag: got %b expected 1", EXTEST); end
    drive(1'b1, 1'b0);
    drive(1'b0, 1'b0);
    checks++; if (BSR_CAPTURE !== 1'b1 || BSR_SHIFT !== 1'b0) begin errors++; $display("FAIL ext_cap: got cap=%b sh=%b expected 1/0", BSR_CAPTURE, BSR_SHIFT); end
    for (int i = 0; i < 4; i++) begin
      BSR_SO = so_pat[i];
      drive(1'b0, 1'b0);
      checks++;
      if (STATE !== 4'd4 || BSR_SHIFT !== 1'b1 || TDO !== so_pat[i]) begin
        errors++; $display("FAIL ext_shift%0d: got state=%0d sh=%b tdo=%b expected 4/1/%b", i, STATE, BSR_SHIFT, TDO, so_pat[i]);
      end
    end
    BSR_SO = 1'b0;
    drive(1'b1, 1'b0);
    drive(1'b1, 1'b0);
    checks++; if (BSR_UPDATE !== 1'b1 || BSR_SHIFT !== 1'b0) begin errors++; $display("FAIL ext_upd: got upd=%b sh=%b expected 1/0", BSR_UPDATE, BSR_SHIFT); end
    drive(1'b0, 1'b0);
    checks++; if (BSR_UPDATE !== 1'b0) begin errors++; $display("FAIL ext_upd_clr: got %b expected 0", BSR_UPDATE); end
  endtask

  task automatic test_idcode_strobes;
    load_ir(4'h2);
    checks++; if (EXTEST !== 1'b0 || IR !== 4'h2) begin errors++; $display("FAIL ids_ir: got ext=%b ir=%0h expected 0/2", EXTEST, IR); end
    BSR_SO = 1'b0;
    drive(1'b1, 1'b0);
    drive(1'b0, 1'b0);
    checks++; if (BSR_CAPTURE !== 1'b0) begin errors++; $display("FAIL ids_cap: got %b expected 0", BSR_CAPTURE); end
    drive(1'b0, 1'b0);
    checks++; if (BSR_SHIFT !== 1'b0 || TDO !== 1'b1) begin errors++; $display("FAIL ids_shift: got sh=%b tdo=%b expected 0/1", BSR_SHIFT, TDO); end
    drive(1'b1, 1'b0);
    drive(1'b1, 1'b0);
    checks++; if (BSR_UPDATE !== 1'b0 || STATE !== 4'd8) begin errors++; $display("FAIL ids_upd: got upd=%b state=%0d expected 0/8", BSR_UPDATE, STATE); end
    drive(1'b0, 1'b0);
  endtask

  task automatic test_trst_mid_shift;
    load_ir(4'hF);
    drive(1'b1, 1'b0);
    drive(1'b0, 1'b0);
    drive(1'b0, 1'b1);
    checks++; if (STATE !== 4'd4 || TDO_EN !== 1'b1 || IR !== 4'hF) begin errors++; $display("FAIL trst_pre: got state=%0d en=%b ir=%0h expected 4/1/f", STATE, TDO_EN, IR); end
    #1 TRST = 1'b1;
    #1;
    checks++; if (STATE !== 4'd0 || TDO_EN !== 1'b0 || IR !== 4'h2) begin errors++; $display("FAIL trst_async: got state=%0d en=%b ir=%0h expected 0/0/2", STATE, TDO_EN, IR); end
    checks++; if (TDO !== 1'b0 || BSR_UPDATE !== 1'b0) begin errors++; $display("FAIL trst_outs: got tdo=%b upd=%b expected 0/0", TDO, BSR_UPDATE); end
    #1 TRST = 1'b0;
    TMS = 1'b1;
    @(negedge TCK);
    #1;
    checks++; if (STATE !== 4'd0) begin errors++; $display("FAIL trst_after: got %0d expected 0", STATE); end
    drive(1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_idcode_scan();
    test_ir_scan();
    test_bypass();
    test_tms_reset();
    test_extest();
    test_idcode_strobes();
    test_trst_mid_shift();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
